// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// Boot loader: length-prefixed LE byte stream -> 32-bit instruction memory writes; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
// Latency: memory write strobe 1 cycle after a word's 4th byte; done/coreResetN rise 1 cycle after the FSM enters DONE.
// Backpressure: byteReady is registered from the next state; the write port never stalls the byte stream.
module imem_loader #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      byteIn,
    input  logic            byteValid,
    output logic            byteReady,
    output logic            memWriteEnable,
    output logic [XLEN-1:0] memAddr,
    output logic [XLEN-1:0] memWriteData,
    output logic            coreResetN,
    output logic            done,
    output logic            error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
`endif

    localparam logic [16:0]         MAX_WORDS = 17'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = (ADDR_WIDTH+1)'(1);

    state_t                state;
    state_t                state_nxt;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [1:0]            byte_cnt;
    logic [23:0]           word_asm;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic                  xfer;
    logic                  word_done;
    logic                  last_word;
    logic [15:0]           len_new;
    logic                  len_ok;
    logic                  load_clear;
    logic                  ready_nxt;

    assign xfer       = byteValid && byteReady;
    assign word_done  = xfer && (state == DATA) && (byte_cnt == 2'd3);
    assign last_word  = (17'(word_idx) + 17'd1) == {1'b0, len_q};
    assign len_new    = {byteIn, len_q[7:0]};
    assign len_ok     = (len_new != 16'd0) && ({1'b0, len_new} <= MAX_WORDS);
    assign load_clear = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LEN_LO;
            LEN_LO:  if (xfer) state_nxt = LEN_HI;
            LEN_HI:  if (xfer) state_nxt = len_ok ? DATA : ERROR;
            DATA: begin
                if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:   if (xfer) state_nxt = (byteIn == csum) ? DONE : ERROR;
`endif
            DONE:    if (start) state_nxt = LEN_LO;
            ERROR:   if (start) state_nxt = LEN_LO;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = 1'b0;
        case (state_nxt)
            LEN_LO, LEN_HI, DATA: ready_nxt = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:                ready_nxt = 1'b1;
`endif
            default:              ready_nxt = 1'b0;
        endcase
    end

    // Status outputs follow the current state, so a start in DONE/ERROR drops them on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byteReady  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            coreResetN <= 1'b0;
        end else begin
            state      <= state_nxt;
            byteReady  <= ready_nxt;
            done       <= (state == DONE) && !start;
            error      <= (state == ERROR) && !start;
            coreResetN <= (state == DONE) && !start;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memWriteEnable <= 1'b0;
            memAddr        <= '0;
            memWriteData   <= '0;
            len_q          <= '0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            word_asm       <= '0;
        end else begin
            memWriteEnable <= word_done;
            if (word_done) begin
                memAddr      <= XLEN'(word_idx) << 2;
                memWriteData <= XLEN'({byteIn, word_asm});
                word_idx     <= word_idx + IDX_ONE;
            end
            if (load_clear) begin
                len_q    <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
                word_asm <= '0;
            end else if (xfer) begin
                case (state)
                    LEN_LO: len_q[7:0]  <= byteIn;
                    LEN_HI: len_q[15:8] <= byteIn;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    word_asm[7:0]   <= byteIn;
                            2'd1:    word_asm[15:8]  <= byteIn;
                            2'd2:    word_asm[23:16] <= byteIn;
                            default: word_asm        <= word_asm;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrapping 8-bit sum over payload bytes only; length bytes are excluded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (load_clear) begin
            csum <= '0;
        end else if (xfer && (state == DATA)) begin
            csum <= csum + byteIn;
        end
    end
`endif

endmodule
